// File: rtl/solver_pio_pkg.sv
// Shared constants for the multi-channel solver input PIO: register offsets,
// edge-type selectors and the channel-count ceiling.
package solver_pio_pkg;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_IRQMASK = 2'd1,
    REG_EDGECAP = 2'd2,
    REG_RSVD    = 2'd3
  } regSel_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int MAX_CH = 8;

endpackage

// File: rtl/solver_pio_sync.sv
// One channel of the solver input PIO: multi-flop synchroniser and, when
// SOLVER_PIO_IRQ_EN is defined, a previous-sample register plus edge detector.
module solver_pio_sync
  import solver_pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_i,
`ifdef SOLVER_PIO_IRQ_EN
  output logic [WIDTH-1:0] det_o,
`endif
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];

`ifdef SOLVER_PIO_IRQ_EN
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= '0;
    else          prev_q <= sync_o;
  end

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : gFall
      assign det_o = ~sync_o & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin : gAny
      assign det_o = sync_o ^ prev_q;
    end else begin : gRise
      assign det_o = sync_o & ~prev_q;
    end
  endgenerate
`endif

endmodule

// File: rtl/solver_pio_in_multi.sv
// Multi-channel synchronised input PIO, Avalon-MM slave with per-bit edge capture
// and level IRQ. The capture/mask/IRQ logic exists only when SOLVER_PIO_IRQ_EN is defined.
module solver_pio_in_multi
  import solver_pio_pkg::*;
#(
  parameter  int WIDTH       = 32,
  parameter  int NUM_CH      = 2,
  parameter  int SYNC_STAGES = 2,
  parameter  int EDGE_TYPE   = EDGE_RISE,
  localparam int AW          = $clog2(NUM_CH) + 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [AW-1:0]           address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  input  logic [NUM_CH*WIDTH-1:0] in_port,
  output logic [31:0]             readdata,
  output logic                    irq
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [WIDTH-1:0] syncVal [NUM_CH];
  logic [CHW-1:0]   chSel;
  logic             chValid;
  regSel_e          regSel;
  logic [31:0]      readdata_q, readdata_d;

  generate
    if (NUM_CH > MAX_CH || NUM_CH < 1) begin : gBadCfg
      $error("solver_pio_in_multi: NUM_CH out of range");
    end
    if (NUM_CH > 1) begin : gChSel
      assign chSel = address[AW-1:2];
    end else begin : gChSelOne
      assign chSel = '0;
    end
  endgenerate

  assign regSel  = regSel_e'(address[1:0]);
  assign chValid = (int'(chSel) < NUM_CH);

`ifdef SOLVER_PIO_IRQ_EN
  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] det       [NUM_CH];
  logic [WIDTH-1:0] clrVec    [NUM_CH];
  logic [WIDTH-1:0] mask_q    [NUM_CH];
  logic [WIDTH-1:0] mask_d    [NUM_CH];
  logic [WIDTH-1:0] edgecap_q [NUM_CH];
  logic [WIDTH-1:0] edgecap_d [NUM_CH];
  logic [2:0]       armCnt_q, armCnt_d;
  logic             armed, wrEn;
  logic             irq_q, irq_d;
`else
  logic unusedWr;
  assign unusedWr = ^{chipselect, write_n, writedata};
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    solver_pio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
    ) uSync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (in_port[c*WIDTH +: WIDTH]),
`ifdef SOLVER_PIO_IRQ_EN
      .det_o   (det[c]),
`endif
      .sync_o  (syncVal[c])
    );
  end

`ifdef SOLVER_PIO_IRQ_EN
  // Edges are ignored until the synchronisers have flushed their reset zeros,
  // so lines already high at reset release do not raise a capture.
  always_comb begin
    armed    = (armCnt_q == ARM_MAX);
    armCnt_d = armed ? armCnt_q : armCnt_q + 3'd1;
    wrEn     = chipselect & ~write_n & chValid;
    irq_d    = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      mask_d[c] = mask_q[c];
      clrVec[c] = '0;
      if (wrEn && int'(chSel) == c && regSel == REG_IRQMASK) mask_d[c] = writedata[WIDTH-1:0];
      if (wrEn && int'(chSel) == c && regSel == REG_EDGECAP) clrVec[c] = writedata[WIDTH-1:0];
      edgecap_d[c] = (edgecap_q[c] & ~clrVec[c]) | (armed ? det[c] : '0);
      irq_d        = irq_d | (|(edgecap_q[c] & mask_q[c]));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armCnt_q <= '0;
      irq_q    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        mask_q[c]    <= '0;
        edgecap_q[c] <= '0;
      end
    end else begin
      armCnt_q <= armCnt_d;
      irq_q    <= irq_d;
      for (int c = 0; c < NUM_CH; c++) begin
        mask_q[c]    <= mask_d[c];
        edgecap_q[c] <= edgecap_d[c];
      end
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    readdata_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chValid && int'(chSel) == c) begin
        case (regSel)
          REG_DATA:    readdata_d = 32'(syncVal[c]);
`ifdef SOLVER_PIO_IRQ_EN
          REG_IRQMASK: readdata_d = 32'(mask_q[c]);
          REG_EDGECAP: readdata_d = 32'(edgecap_q[c]);
`endif
          default:     readdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_solver_pio_in_multi.sv
// Self-checking bench for solver_pio_in_multi (3 channels, so one channel index is
// unmapped). Expectations follow SOLVER_PIO_IRQ_EN in the same way the design does.
module tb_solver_pio_in_multi;

  localparam int NCH = 3;
  localparam int W   = 32;
  localparam int SS  = 2;
`ifdef SOLVER_PIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [3:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [NCH*W-1:0]  in_port;
  logic [31:0]       readdata;
  logic              irq;

  solver_pio_in_multi #(
    .WIDTH       (W),
    .NUM_CH      (NCH),
    .SYNC_STAGES (SS),
    .EDGE_TYPE   (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: input history indexed by cycle since reset release,
  // plus the register contents the CPU can see.
  logic [NCH*W-1:0] inHist [$];
  int               tCyc;
  logic [31:0]      eModel [NCH];
  logic [31:0]      mModel [NCH];
  logic [NCH*W-1:0] inVec;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NCH*W-1:0] syncAt(input int t);
    if (t >= SS && (t - SS) < inHist.size()) return inHist[t-SS];
    return '0;
  endfunction

  function automatic logic modelIrq();
    logic r = 1'b0;
    for (int c = 0; c < NCH; c++) r = r | (|(eModel[c] & mModel[c]));
    return r;
  endfunction

  task automatic resetModel();
    inHist.delete();
    tCyc = 0;
    for (int c = 0; c < NCH; c++) begin
      eModel[c] = '0;
      mModel[c] = '0;
    end
  endtask

  // One bus cycle: drive, predict, clock, then compare outputs against the prediction.
  task automatic applyStimulus(input logic [3:0] a, input logic cs, input logic wn,
                               input logic [31:0] wd, input logic [NCH*W-1:0] inv);
    logic [NCH*W-1:0] sCur, sPrev;
    logic [31:0]      expRd, det, clr;
    logic [31:0]      eNext [NCH];
    logic [31:0]      mNext [NCH];
    logic             expIrq, wr;
    int               ch;
    address = a; chipselect = cs; write_n = wn; writedata = wd; in_port = inv;
    inHist.push_back(inv);
    sCur  = syncAt(tCyc);
    sPrev = syncAt(tCyc - 1);
    ch    = int'(a[3:2]);
    wr    = cs && !wn;
    expRd = '0;
    if (ch < NCH) begin
      if (a[1:0] == 2'd0)      expRd = sCur[ch*W +: W];
      else if (a[1:0] == 2'd1) expRd = mModel[ch];
      else if (a[1:0] == 2'd2) expRd = eModel[ch];
    end
    expIrq = modelIrq();
    for (int c = 0; c < NCH; c++) begin
      det = (tCyc >= SS + 1) ? (sCur[c*W +: W] & ~sPrev[c*W +: W]) : '0;
      clr = (wr && ch == c && a[1:0] == 2'd2) ? wd : '0;
      eNext[c] = IRQ_EN ? ((eModel[c] & ~clr) | det) : '0;
      mNext[c] = (IRQ_EN && wr && ch == c && a[1:0] == 2'd1) ? wd : mModel[c];
    end
    @(posedge clk); #1;
    tCyc++;
    for (int c = 0; c < NCH; c++) begin
      eModel[c] = eNext[c];
      mModel[c] = mNext[c];
    end
    checkOutput("rdata", readdata, expRd);
    checkOutput("irq", {31'b0, irq}, {31'b0, expIrq});
  endtask

  task automatic idle(input logic [3:0] a, input int n);
    for (int i = 0; i < n; i++) applyStimulus(a, 1'b1, 1'b1, 32'h0, inVec);
  endtask

  task automatic randomRun(input int n);
    logic [31:0] wd;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < NCH; c++) inVec[c*W +: W] = inVec[c*W +: W] ^ ($urandom & $urandom & $urandom);
      wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), wd, inVec);
    end
  endtask

  initial begin
    address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    reset_n = 1'b0;
    inVec = '0;
    inVec[W-1:0] = 32'hFFFF_FFFF;
    in_port = inVec;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rdata", readdata, 32'h0);
    checkOutput("rst_irq", {31'b0, irq}, 32'h0);

    // Line held high through reset must not produce a capture.
    reset_n = 1'b1;
    idle(4'd2, 10);
    checkOutput("t1_edgecap0", readdata, 32'h0);
    checkOutput("t1_irq", {31'b0, irq}, 32'h0);
    idle(4'd0, 1);
    checkOutput("t1_data0", readdata, 32'hFFFF_FFFF);

    // DATA latency: synchroniser depth plus the registered read.
    inVec[W +: W] = 32'h0000_00A5;
    for (int j = 1; j <= 3; j++) begin
      applyStimulus(4'd4, 1'b1, 1'b1, 32'h0, inVec);
      if (j == 2) checkOutput("t2_early", readdata, 32'h0);
      if (j == 3) checkOutput("t2_data1", readdata, 32'h0000_00A5);
    end

    // Rising edge on ch0 bit0 with mask, then W1C.
    inVec[0] = 1'b0;
    idle(4'd0, 5);
    applyStimulus(4'd1, 1'b1, 1'b0, 32'h1, inVec);
    inVec[0] = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      applyStimulus(4'd2, 1'b1, 1'b1, 32'h0, inVec);
      if (j == 3) checkOutput("t3_irq_early", {31'b0, irq}, 32'h0);
      if (j == 4) begin
        checkOutput("t3_edgecap0", readdata, IRQ_EN ? 32'h1 : 32'h0);
        checkOutput("t3_irq", {31'b0, irq}, {31'b0, IRQ_EN});
      end
    end
    applyStimulus(4'd2, 1'b1, 1'b0, 32'h1, inVec);
    checkOutput("t3_irq_hold", {31'b0, irq}, {31'b0, IRQ_EN});
    applyStimulus(4'd2, 1'b1, 1'b1, 32'h0, inVec);
    checkOutput("t3_irq_clr", {31'b0, irq}, 32'h0);
    checkOutput("t3_edgecap_clr", readdata, 32'h0);

    // Collision: new edge on bit3 in the same cycle as its W1C.
    inVec[3] = 1'b0; idle(4'd0, 4);
    inVec[3] = 1'b1; idle(4'd0, 4);
    inVec[3] = 1'b0; idle(4'd0, 4);
    inVec[3] = 1'b1; idle(4'd0, 2);
    applyStimulus(4'd2, 1'b1, 1'b0, 32'h8, inVec);
    applyStimulus(4'd2, 1'b1, 1'b1, 32'h0, inVec);
    checkOutput("t4_collide", readdata & 32'h8, IRQ_EN ? 32'h8 : 32'h0);

    // Unmapped channel and reserved register.
    applyStimulus(4'd12, 1'b1, 1'b1, 32'h0, inVec);
    checkOutput("t5_ch3", readdata, 32'h0);
    applyStimulus(4'd3, 1'b1, 1'b1, 32'h0, inVec);
    checkOutput("t5_rsvd", readdata, 32'h0);
    applyStimulus(4'd13, 1'b1, 1'b0, 32'hFFFF_FFFF, inVec);
    applyStimulus(4'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, inVec);
    applyStimulus(4'd14, 1'b1, 1'b0, 32'hFFFF_FFFF, inVec);
    applyStimulus(4'd1, 1'b1, 1'b1, 32'h0, inVec);
    checkOutput("t5_mask0", readdata, IRQ_EN ? 32'h1 : 32'h0);

    // Full mask then random toggling.
    applyStimulus(4'd1, 1'b1, 1'b0, 32'hFFFF_FFFF, inVec);
    for (int i = 0; i < 6; i++) begin
      inVec[W-1:0] = inVec[W-1:0] ^ $urandom;
      applyStimulus(4'd2, 1'b1, 1'b1, 32'h0, inVec);
    end
    applyStimulus(4'd1, 1'b1, 1'b1, 32'h0, inVec);
    checkOutput("t6_mask0", readdata, IRQ_EN ? 32'hFFFF_FFFF : 32'h0);

    randomRun(1500);

    // Asynchronous reset in the middle of traffic.
    reset_n = 1'b0;
    #1;
    checkOutput("arst_rdata", readdata, 32'h0);
    checkOutput("arst_irq", {31'b0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetModel();
    reset_n = 1'b1;
    randomRun(800);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
